// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared framebuffer geometry, coordinate widths and draw-engine state type
package fb_pkg;

    // Visible framebuffer geometry (320x200, 8 bits per pixel).
    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 200;

    // Coordinate and pixel widths used by every framebuffer client.
    localparam int X_W   = 9;
    localparam int Y_W   = 8;
    localparam int PIX_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLIP = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } fill_state_t;

endpackage

// File: rtl/rect_fill.sv
// rtl/rect_fill.sv - rectangle fill engine clipping commands to the screen and emitting raster-order pixel writes
//
// Ports:
//   clk, reset                    system clock, synchronous active-high reset
//   cmd_valid / cmd_ready         command handshake (ready only while idle)
//   cmd_x, cmd_y, cmd_w, cmd_h    rectangle origin and size, unsigned
//   cmd_color                     fill value
//   write_enable, write_x,
//   write_y, write_data           one pixel write per clock to the framebuffer
//   busy                          a command is in progress
//   done                          one-cycle pulse when a command completes
module rect_fill
    import fb_pkg::*;
#(
    parameter int FB_WIDTH  = fb_pkg::FB_WIDTH,
    parameter int FB_HEIGHT = fb_pkg::FB_HEIGHT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [X_W-1:0]   cmd_x,
    input  logic [Y_W-1:0]   cmd_y,
    input  logic [X_W-1:0]   cmd_w,
    input  logic [Y_W-1:0]   cmd_h,
    input  logic [PIX_W-1:0] cmd_color,
    output logic             write_enable,
    output logic [X_W-1:0]   write_x,
    output logic [Y_W-1:0]   write_y,
    output logic [PIX_W-1:0] write_data,
    output logic             busy,
    output logic             done
);

    localparam logic [X_W:0] X_LIM = (X_W+1)'(FB_WIDTH);
    localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(FB_HEIGHT);

    fill_state_t      state;

    // Command fields captured at acceptance; later cmd_* activity is ignored.
    logic [X_W-1:0]   lat_x;
    logic [Y_W-1:0]   lat_y;
    logic [X_W-1:0]   lat_w;
    logic [Y_W-1:0]   lat_h;
    logic [PIX_W-1:0] color;

    logic [X_W-1:0]   cur_x;
    logic [Y_W-1:0]   cur_y;
    logic [X_W-1:0]   x_end;
    logic [Y_W-1:0]   y_end;

    // Clip arithmetic, used only in CLIP. Sums carry one extra bit so
    // cmd_x+cmd_w and cmd_y+cmd_h cannot wrap.
    logic [X_W:0]     x_sum;
    logic [Y_W:0]     y_sum;
    logic [X_W:0]     x_lim_sum;
    logic [Y_W:0]     y_lim_sum;
    logic [X_W:0]     x_last;
    logic [Y_W:0]     y_last;
    logic             empty;

    always_comb begin
        x_sum     = {1'b0, lat_x} + {1'b0, lat_w};
        y_sum     = {1'b0, lat_y} + {1'b0, lat_h};
        x_lim_sum = (x_sum > X_LIM) ? X_LIM : x_sum;
        y_lim_sum = (y_sum > Y_LIM) ? Y_LIM : y_sum;
        x_last    = x_lim_sum - (X_W+1)'(1);
        y_last    = y_lim_sum - (Y_W+1)'(1);
        // An empty rectangle never reaches FILL, so the -1 above only
        // matters for commands with at least one on-screen pixel.
        empty     = (lat_w == '0) || (lat_h == '0) ||
                    ({1'b0, lat_x} >= X_LIM) || ({1'b0, lat_y} >= Y_LIM);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            lat_x <= '0;
            lat_y <= '0;
            lat_w <= '0;
            lat_h <= '0;
            color <= '0;
            cur_x <= '0;
            cur_y <= '0;
            x_end <= '0;
            y_end <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        lat_x <= cmd_x;
                        lat_y <= cmd_y;
                        lat_w <= cmd_w;
                        lat_h <= cmd_h;
                        color <= cmd_color;
                        state <= CLIP;
                    end
                end
                CLIP: begin
                    x_end <= x_last[X_W-1:0];
                    y_end <= y_last[Y_W-1:0];
                    if (empty) begin
                        state <= DONE;
                    end else begin
                        cur_x <= lat_x;
                        cur_y <= lat_y;
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (cur_x == x_end) begin
                        if (cur_y == y_end) begin
                            state <= DONE;
                        end else begin
                            cur_x <= lat_x;
                            cur_y <= cur_y + 1'b1;
                        end
                    end else begin
                        cur_x <= cur_x + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Every output comes from registers only: either decoded state or the
    // raster position / latched color.
    always_comb begin
        cmd_ready    = (state == IDLE);
        busy         = (state != IDLE);
        done         = (state == DONE);
        write_enable = (state == FILL);
        write_x      = cur_x;
        write_y      = cur_y;
        write_data   = color;
    end

endmodule

// File: tb/tb_rect_fill.sv
// tb/tb_rect_fill.sv - self-checking bench for rect_fill against a clip-and-raster reference model
module tb_rect_fill;

    localparam int W = 320;
    localparam int H = 200;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [8:0] cmd_x = '0;
    logic [7:0] cmd_y = '0;
    logic [8:0] cmd_w = '0;
    logic [7:0] cmd_h = '0;
    logic [7:0] cmd_color = '0;
    logic       write_enable;
    logic [8:0] write_x;
    logic [7:0] write_y;
    logic [7:0] write_data;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    logic [7:0] fb [0:W*H-1];

    rect_fill dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_x        (cmd_x),
        .cmd_y        (cmd_y),
        .cmd_w        (cmd_w),
        .cmd_h        (cmd_h),
        .cmd_color    (cmd_color),
        .write_enable (write_enable),
        .write_x      (write_x),
        .write_y      (write_y),
        .write_data   (write_data),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Presents a command and returns once it has been accepted at a posedge.
    task automatic issue(input int x, input int y, input int w, input int h,
                         input int c, output int waited);
        @(negedge clk);
        cmd_x     = 9'(x);
        cmd_y     = 8'(y);
        cmd_w     = 9'(w);
        cmd_h     = 8'(h);
        cmd_color = 8'(c);
        cmd_valid = 1'b1;
        waited    = 0;
        while (!cmd_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("issue_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
    endtask

    // Follows one accepted command cycle by cycle (k = cycles after
    // acceptance) and compares against the clipped raster expectation.
    // With scramble set, cmd_valid stays high and the fields change every
    // cycle to show that only the latched command is drawn.
    task automatic collect(input int x, input int y, input int w, input int h,
                           input int c, input bit scramble, input string tag);
        int ex_x[$];
        int ex_y[$];
        int xe, ye, n, idx, bad, ctrl_bad, done_k;
        ex_x.delete();
        ex_y.delete();
        if (w > 0 && h > 0 && x < W && y < H) begin
            xe = (x + w > W) ? W : x + w;
            ye = (y + h > H) ? H : y + h;
            for (int yy = y; yy < ye; yy++)
                for (int xx = x; xx < xe; xx++) begin
                    ex_x.push_back(xx);
                    ex_y.push_back(yy);
                end
        end
        n = ex_x.size();
        idx = 0; bad = 0; ctrl_bad = 0; done_k = -1;
        for (int k = 1; k <= n + 10; k++) begin
            @(negedge clk);
            if (scramble) begin
                cmd_x     = 9'($urandom_range(0, 511));
                cmd_y     = 8'($urandom_range(0, 255));
                cmd_w     = 9'($urandom_range(0, 511));
                cmd_h     = 8'($urandom_range(0, 255));
                cmd_color = 8'($urandom);
            end else if (k == 1) begin
                cmd_valid = 1'b0;
                cmd_x     = 9'($urandom);
                cmd_color = 8'($urandom);
            end
            if (write_enable !== ((k >= 2 && k <= n + 1) ? 1'b1 : 1'b0)) ctrl_bad++;
            if (busy !== 1'b1 || cmd_ready !== 1'b0) ctrl_bad++;
            if (done !== ((k == n + 2) ? 1'b1 : 1'b0)) ctrl_bad++;
            if (write_enable === 1'b1) begin
                if (int'(write_x) >= W || int'(write_y) >= H) begin
                    bad++;
                end else begin
                    fb[int'(write_y) * W + int'(write_x)] = write_data;
                    if (idx >= n || int'(write_x) != ex_x[idx] ||
                        int'(write_y) != ex_y[idx] || int'(write_data) != c)
                        bad++;
                end
                idx++;
            end
            if (done === 1'b1) begin
                done_k = k;
                break;
            end
        end
        chk($sformatf("%s_nwrites", tag), 32'(idx), 32'(n));
        chk($sformatf("%s_pixels", tag), 32'(bad), 32'd0);
        chk($sformatf("%s_done_cycle", tag), 32'(done_k), 32'(n + 2));
        chk($sformatf("%s_ctrl", tag), 32'(ctrl_bad), 32'd0);
        if (!scramble) begin
            @(negedge clk);
            chk($sformatf("%s_idle_after", tag),
                {28'd0, cmd_ready, busy, done, write_enable}, 32'b1000);
        end
    endtask

    initial begin
        int waited, bad, x, y, w, h, c;

        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {28'd0, cmd_ready, busy, done, write_enable}, 32'b1000);
        chk("rst_write_x", 32'(write_x), 32'd0);
        chk("rst_write_y", 32'(write_y), 32'd0);
        chk("rst_write_data", 32'(write_data), 32'd0);
        reset = 1'b0;

        // Basic 3x2 fill
        issue(10, 20, 3, 2, 8'h5A, waited);
        collect(10, 20, 3, 2, 8'h5A, 1'b0, "basic");

        // Bottom-right corner clipping
        issue(318, 198, 5, 5, 8'hFF, waited);
        collect(318, 198, 5, 5, 8'hFF, 1'b0, "corner");

        // Empty commands
        issue(40, 40, 0, 7, 8'h12, waited);
        collect(40, 40, 0, 7, 8'h12, 1'b0, "w0");
        issue(320, 10, 4, 4, 8'h34, waited);
        collect(320, 10, 4, 4, 8'h34, 1'b0, "x320");
        issue(5, 200, 4, 4, 8'h56, waited);
        collect(5, 200, 4, 4, 8'h56, 1'b0, "y200");

        // Randomized commands, biased to straddle the right/bottom edges
        for (int i = 0; i < 14; i++) begin
            x = $urandom_range(0, 330);
            y = $urandom_range(0, 210);
            w = $urandom_range(0, 24);
            h = $urandom_range(0, 12);
            c = $urandom_range(0, 255);
            issue(x, y, w, h, c, waited);
            collect(x, y, w, h, c, 1'b0, $sformatf("rand%0d", i));
        end

        // Full screen fill, then read back the whole framebuffer model
        for (int a = 0; a < W * H; a++) fb[a] = 8'hAA;
        issue(0, 0, W, H, 8'h00, waited);
        collect(0, 0, W, H, 8'h00, 1'b0, "full");
        bad = 0;
        for (int a = 0; a < W * H; a++) if (fb[a] !== 8'h00) bad++;
        chk("full_readback", 32'(bad), 32'd0);

        // Reset on the 5th write of a 4x4 fill
        issue(50, 60, 4, 4, 8'h3C, waited);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
        end
        chk("rst5_we", {31'd0, write_enable}, 32'd1);
        chk("rst5_pos", {16'd0, 7'd0, write_x, write_y}, {16'd0, 7'd0, 9'd50, 8'd61});
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst5_after", {28'd0, cmd_ready, busy, done, write_enable}, 32'b1000);
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || write_enable !== 1'b0) bad++;
        end
        chk("rst5_quiet", 32'(bad), 32'd0);
        issue(7, 8, 1, 1, 8'h11, waited);
        collect(7, 8, 1, 1, 8'h11, 1'b0, "post_rst");

        // cmd_valid held with changing fields during a fill
        issue(100, 50, 4, 2, 8'h33, waited);
        collect(100, 50, 4, 2, 8'h33, 1'b1, "held1");
        issue(200, 150, 2, 1, 8'h77, waited);
        chk("held_accept_wait", 32'(waited), 32'd0);
        collect(200, 150, 2, 1, 8'h77, 1'b0, "held2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
